// File: rtl/issue_arb_pkg.sv
// Shared types, defaults and helpers for the issue arbiter.
//   arb_dir_t : priority direction (DIR_LO = lowest index wins, DIR_HI = highest)
//   N_ENT_DEF : default number of RS entries arbitrated
//   AGE_MAX_DEF : default starvation threshold (only used with ISSUE_ARB_AGE_EN)
//   oh2idx    : one-hot (up to 64 bits) to binary index
package issue_arb_pkg;

  localparam int N_ENT_DEF   = 8;
  localparam int AGE_MAX_DEF = 7;

  typedef enum logic {DIR_LO = 1'b0, DIR_HI = 1'b1} arb_dir_t;

  // OR-encoder: exact for one-hot inputs, 0 for an all-zero input.
  function automatic logic [5:0] oh2idx(input logic [63:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ps_tree_dir.sv
// Direction-selectable priority tree, combinational only.
//   req    in  N_ENT  request per leaf
//   en     in  1      tree enable (grant allowed out of the root)
//   sel    in  1      0 = lowest index wins, 1 = highest index wins
//   gnt    out N_ENT  one-hot grant (0 when no request or !en)
//   req_up out 1      OR of all requests
// Built recursively: each level is one 2-input cell fed by two half-size
// subtrees, bottoming out at a single cell over two leaves.
module ps_dir_cell (
  input  logic req_l,
  input  logic req_r,
  input  logic en,
  input  logic sel,
  output logic gnt_l,
  output logic gnt_r,
  output logic req_up
);
  // Left side is the lower index half; sel picks which side wins a tie.
  assign gnt_l  = en & req_l & (~sel | ~req_r);
  assign gnt_r  = en & req_r & ( sel | ~req_l);
  assign req_up = req_l | req_r;
endmodule

module ps_tree_dir
  import issue_arb_pkg::*;
#(
  parameter int N_ENT = N_ENT_DEF
) (
  input  logic [N_ENT-1:0] req,
  input  logic             en,
  input  logic             sel,
  output logic [N_ENT-1:0] gnt,
  output logic             req_up
);
  if (N_ENT == 2) begin : g_base
    ps_dir_cell u_cell (
      .req_l (req[0]), .req_r (req[1]), .en, .sel,
      .gnt_l (gnt[0]), .gnt_r (gnt[1]), .req_up
    );
  end else begin : g_split
    localparam int H = N_ENT / 2;
    logic up_lo, up_hi, en_lo, en_hi;

    ps_dir_cell u_cell (
      .req_l (up_lo), .req_r (up_hi), .en, .sel,
      .gnt_l (en_lo), .gnt_r (en_hi), .req_up
    );

    ps_tree_dir #(.N_ENT(H)) u_lo (
      .req (req[H-1:0]), .en (en_lo), .sel,
      .gnt (gnt[H-1:0]), .req_up (up_lo)
    );

    ps_tree_dir #(.N_ENT(H)) u_hi (
      .req (req[N_ENT-1:H]), .en (en_hi), .sel,
      .gnt (gnt[N_ENT-1:H]), .req_up (up_hi)
    );
  end
endmodule

// File: rtl/issue_arb.sv
// Registered single-issue arbiter between RS ready bits and one FU issue port.
//   clock, reset_n : clock (rising edge), asynchronous active-low reset
//   req            : per-entry ready-to-issue
//   en             : issue enable; 0 blocks new selections only
//   flush          : synchronous squash of the held grant
//   out_ready      : FU accepts the held grant this cycle
//   out_valid/out_gnt/out_idx : held grant (one-hot and binary index)
//   issued_oh      : comb, held grant gated by the handshake; RS clears the entry
//   dir            : current priority direction (0 = low wins, 1 = high wins)
// Optional feature: define ISSUE_ARB_AGE_EN for per-entry starvation counters
// that override the tree with the lowest-index starved entry.
module issue_arb
  import issue_arb_pkg::*;
#(
  parameter int N_ENT   = N_ENT_DEF,
  parameter int IDX_W   = $clog2(N_ENT),
  parameter int AGE_MAX = AGE_MAX_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_ENT-1:0] req,
  input  logic             en,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N_ENT-1:0] out_gnt,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_ENT-1:0] issued_oh,
  output logic             dir
);

  logic             valid_q, valid_d;
  logic [N_ENT-1:0] gnt_q, gnt_d;
  arb_dir_t         dir_q, dir_d;

  logic [N_ENT-1:0] req_m, tree_gnt, starved, pick;
  logic             any_req, accept, load;

  // The held entry is still requesting until the RS sees issued_oh; mask it.
  assign req_m  = req & ~(valid_q ? gnt_q : '0);
  assign accept = valid_q & out_ready;
  assign load   = en & any_req & (~valid_q | out_ready) & ~flush;

  always_comb begin
    dir_d = dir_q;
    if (accept && !flush) dir_d = (dir_q == DIR_LO) ? DIR_HI : DIR_LO;
  end

  // The tree sees the direction in force after this edge, so a back-to-back
  // reload on an accept already uses the flipped priority.
  ps_tree_dir #(.N_ENT(N_ENT)) u_tree (
    .req    (req_m),
    .en     (1'b1),
    .sel    (dir_d == DIR_HI),
    .gnt    (tree_gnt),
    .req_up (any_req)
  );

  // Lowest starved entry (x & -x) beats the tree.
  assign pick = (|starved) ? (starved & (~starved + N_ENT'(1))) : tree_gnt;

  always_comb begin
    valid_d = valid_q;
    gnt_d   = gnt_q;
    if (flush) begin
      valid_d = 1'b0;
      gnt_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      gnt_d   = pick;
    end else if (accept) begin
      valid_d = 1'b0;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      gnt_q   <= '0;
      dir_q   <= DIR_LO;
    end else begin
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      dir_q   <= dir_d;
    end
  end

`ifdef ISSUE_ARB_AGE_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  for (genvar i = 0; i < N_ENT; i++) begin : g_age
    logic [AGE_W-1:0] age_q, age_d;

    // Held (masked) entries neither age nor clear: they were just loaded.
    always_comb begin
      age_d = age_q;
      if (flush || !req[i] || (load && pick[i])) begin
        age_d = '0;
      end else if (req_m[i] && (age_q != AGE_W'(AGE_MAX))) begin
        age_d = age_q + AGE_W'(1);
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) age_q <= '0;
      else          age_q <= age_d;
    end

    assign starved[i] = req_m[i] & (age_q == AGE_W'(AGE_MAX));
  end
`else
  logic unused_age_max;
  assign unused_age_max = (AGE_MAX > 0);
  assign starved        = '0;
`endif

  assign out_valid = valid_q;
  assign out_gnt   = gnt_q;
  assign out_idx   = IDX_W'(oh2idx(64'(gnt_q)));
  assign issued_oh = gnt_q & {N_ENT{accept}};
  assign dir       = dir_q;

endmodule

// File: tb/tb_issue_arb.sv
// Bench for issue_arb: reset, directed table, starvation sequence and
// randomized traffic, all checked against a behavioural model of the
// arbitration rules. Works for both builds (ISSUE_ARB_AGE_EN on or off).
module tb_issue_arb;
  localparam int N  = 8;
  localparam int AM = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         en = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic         out_valid;
  logic [N-1:0] out_gnt;
  logic [2:0]   out_idx;
  logic [N-1:0] issued_oh;
  logic         dir;

  issue_arb #(.N_ENT(N), .AGE_MAX(AM)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .en        (en),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_gnt   (out_gnt),
    .out_idx   (out_idx),
    .issued_oh (issued_oh),
    .dir       (dir)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  bit m_valid;
  int m_idx;
  bit m_dir;
  int m_age[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] m_gnt();
    return m_valid ? (N'(1) << m_idx) : '0;
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int highest(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_dir   = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input bit e, input bit f, input bit rd);
    logic [N-1:0] rm;
    bit acc, ld, edir;
    int pk;
    rm   = r & ~m_gnt();
    acc  = m_valid && rd;
    edir = m_dir ^ (acc && !f);
    ld   = e && (rm != 0) && (!m_valid || rd) && !f;
    pk   = -1;
`ifdef ISSUE_ARB_AGE_EN
    for (int i = 0; i < N; i++) if (pk < 0 && rm[i] && m_age[i] == AM) pk = i;
`endif
    if (pk < 0) pk = edir ? highest(rm) : lowest(rm);
`ifdef ISSUE_ARB_AGE_EN
    for (int i = 0; i < N; i++) begin
      if (f || !r[i] || (ld && pk == i)) m_age[i] = 0;
      else if (rm[i] && m_age[i] < AM)   m_age[i] = m_age[i] + 1;
    end
`endif
    if (f) m_valid = 0;
    else if (ld) begin m_valid = 1; m_idx = pk; end
    else if (acc) m_valid = 0;
    if (!m_valid) m_idx = 0;
    m_dir = edir;
  endtask

  // One cycle: drive at negedge, check outputs against the model, advance.
  task automatic cyc(input logic [N-1:0] r, input bit e, input bit f, input bit rd);
    @(negedge clock);
    req = r; en = e; flush = f; out_ready = rd;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_gnt", {24'b0, out_gnt}, {24'b0, m_gnt()});
    chk("out_idx", {29'b0, out_idx}, m_idx);
    chk("dir", {31'b0, dir}, {31'b0, m_dir});
    chk("issued_oh", {24'b0, issued_oh}, {24'b0, (m_valid && rd) ? m_gnt() : '0});
    model_step(r, e, f, rd);
    @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 0; req = 8'hFF; en = 1; flush = 0; out_ready = 0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_gnt", {24'b0, out_gnt}, 0);
    chk("rst_idx", {29'b0, out_idx}, 0);
    chk("rst_dir", {31'b0, dir}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    req = '0; en = 0;
    reset_n = 1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    bit           en, flush, rdy;
    bit           e_valid;
    int           e_idx;
    bit           e_dir;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int seen3, alt_ok, prev, nsmp;

    // expected state after each edge, starting from reset
    tbl[0]  = '{8'b0010_0100, 1, 0, 1, 1, 2, 0};
    tbl[1]  = '{8'b0010_0000, 1, 0, 1, 1, 5, 1};
    tbl[2]  = '{8'h00,        1, 0, 1, 0, 0, 0};
    tbl[3]  = '{8'b1000_0001, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{8'b1000_0001, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{8'b1000_0001, 1, 0, 0, 1, 0, 0};
    tbl[6]  = '{8'b1000_0001, 1, 0, 1, 1, 7, 1};
    tbl[7]  = '{8'b1000_0001, 1, 0, 0, 1, 7, 1};
    tbl[8]  = '{8'b1000_0001, 1, 1, 0, 0, 0, 1};
    tbl[9]  = '{8'h00,        1, 0, 1, 0, 0, 1};
    tbl[10] = '{8'b0000_0010, 1, 0, 0, 1, 1, 1};
    tbl[11] = '{8'b0000_0010, 1, 1, 1, 0, 0, 1};
    tbl[12] = '{8'hFF,        0, 0, 1, 0, 0, 1};
    tbl[13] = '{8'hFF,        0, 0, 1, 0, 0, 1};
    tbl[14] = '{8'hFF,        0, 0, 1, 0, 0, 1};

    // reset and first pick
    do_reset();
    cyc(8'hFF, 1, 0, 0);
    #1;
    chk("t1_valid", {31'b0, out_valid}, 1);
    chk("t1_idx", {29'b0, out_idx}, 0);

    // directed table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].req, tbl[i].en, tbl[i].flush, tbl[i].rdy);
      #1;
      chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("row%0d_idx", i), {29'b0, out_idx}, tbl[i].e_idx);
      chk($sformatf("row%0d_dir", i), {31'b0, dir}, {31'b0, tbl[i].e_dir});
    end

    // starvation: entries 0, 3, 7 always ready, FU always accepting
    do_reset();
    seen3 = 0; alt_ok = 1; prev = -1; nsmp = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(8'b1000_1001, 1, 0, 1);
      #1;
      if (out_valid) begin
`ifdef ISSUE_ARB_AGE_EN
        if (c < 4 && out_idx == 3) seen3 = 1;
`else
        if (out_idx == 3) seen3 = 1;
        if (!(out_idx == 0 || out_idx == 7) || int'(out_idx) == prev) alt_ok = 0;
`endif
        prev = int'(out_idx);
        nsmp++;
      end
    end
`ifdef ISSUE_ARB_AGE_EN
    chk("t6_idx3_by_cycle4", seen3, 1);
`else
    chk("t6_no_idx3", seen3, 0);
    chk("t6_alternate_0_7", alt_ok, 1);
`endif
    chk("t6_samples", nsmp, 10);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      r = (c % 3 == 0) ? N'($urandom) : N'($urandom & $urandom);
      cyc(r, ($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
